average_image_divider: RTL and testbench
========================================

// Module: average_image_divider
// PURPOSE
//  Downstream of the image-summing stage. Takes the 784-pixel accumulated sum image
//  (24 b/pixel) plus the number of images summed, and produces the average image.
//  Uses one pixel per division: a shared sequential restoring divider, one quotient bit/cycle.
//  Streams 8-bit average pixels out with a valid/ready handshake to the classifier/template store.
// PARAMETERS
//  NPIX   784  pixels per image (28x28)
//  SUM_W  24   width of each accumulated pixel sum
//  PIX_W  8    width of each output average pixel
//  CNT_W  16   width of image_count
// PORTS
//  clk          in   1            single clock, rising edge
//  reset        in   1            asynchronous, active-low reset
//  start        in   1            begin averaging; sampled only in IDLE
//  sum_image    in   NPIX*SUM_W   [NPIX-1:0][SUM_W-1:0] sums; held stable by source while busy=1
//  image_count  in   CNT_W        divisor; captured on accepted start
//  busy         out  1            high from accepted start until done
//  pix_valid    out  1            pix_data/pix_index valid
//  out_ready    in   1            consumer accepts pixel when pix_valid&&out_ready
//  pix_data     out  PIX_W        average pixel
//  pix_index    out  $clog2(NPIX) pixel index 0..NPIX-1
//  done         out  1            1-cycle pulse after last pixel accepted
//  err_div_zero out  1            1-cycle pulse: start with image_count==0
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; busy, pix_valid, done, err_div_zero, pix_data, pix_index = 0.
//  Reset mid-operation: the frame is abandoned. After release the block sits in IDLE with no output.
//  FSM: IDLE -> LOAD -> DIVIDE -> OUTPUT -> (LOAD | DONE) -> IDLE.
//  IDLE: start && image_count!=0 -> capture count, idx=0, LOAD.
//    start && image_count==0 -> err_div_zero pulse next cycle, stay IDLE, busy stays 0.
//  LOAD (1 cycle): dividend = zero-extended sum_image[idx] (SUM_W+1 b) (+ rounding term, see CONFIG).
//  DIVIDE (SUM_W+1 cycles): restoring divide, one quotient bit per cycle, MSB first.
//  OUTPUT: pix_valid=1, pix_data = quotient>255 ? 255 : quotient[7:0]; pix_index=idx.
//    pix_data and pix_index stay stable while out_ready=0. On handshake, pix_valid drops next cycle.
//    After the handshake: idx==NPIX-1 -> DONE, else idx++ and LOAD.
//  DONE: done=1 for one cycle, busy=0 from the next cycle, -> IDLE.
//  Minimum per-pixel latency is SUM_W+3 cycles from LOAD to the first pix_valid cycle.
//  start while busy is ignored. Remainder is discarded. No combinational path from out_ready to pix_valid.
// CONFIGURATION
//  AVG_ROUND_EN defined: LOAD adds (count>>1) to the dividend, giving round-half-up.
//    The SUM_W+1 dividend width absorbs the carry.
//  AVG_ROUND_EN undefined: plain truncating divide (floor).
//  Saturation to 255 applies in both builds.
// STRUCTURE
//  Package image_pkg: NPIX, SUM_W, PIX_W, CNT_W, IDX_W=$clog2(NPIX), typedef avg_state_e
//    (IDLE, LOAD, DIVIDE, OUTPUT, DONE), typedef pixel_sum_t / pixel_t.
//  Sub-module seq_divider: start/busy/done, dividend SUM_W+1, divisor CNT_W, quotient SUM_W+1.
//    The top-level FSM, index counter and output register stay in this module.
// TESTING
//  1) count=1, all sums=200 -> 784 pixels of 200, indices 0..783 in order; done 1 cycle after last handshake.
//  2) count=4, sum[0]=10 -> pix_data 2 (no macro) / 3 (AVG_ROUND_EN); sum[1]=3000, count=2 -> 255 (saturate).
//  3) start with image_count=0 -> err_div_zero single pulse, busy=0, no pix_valid ever.
//  4) out_ready low 5 cycles during OUTPUT -> pix_valid held, pix_data/pix_index unchanged; accepted once.
//  5) reset low mid-DIVIDE at pixel 100 -> all outputs 0 immediately; new start restarts at index 0.
//  6) start pulsed while busy -> ignored; count=784, sum=0xFFFFFF -> 21399 -> 255 on all pixels.

Source files
------------

// File: rtl/image_pkg.sv
// Shared parameters, FSM state type and pixel types for the image-averaging path.
package image_pkg;

    localparam int NPIX  = 784;            // 28x28 image
    localparam int SUM_W = 24;             // accumulated per-pixel sum width
    localparam int PIX_W = 8;              // averaged output pixel width
    localparam int CNT_W = 16;             // image_count width
    localparam int IDX_W = $clog2(NPIX);   // pixel index width
    localparam int DIV_W = SUM_W + 1;      // dividend/quotient width (room for rounding carry)

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DIVIDE = 3'd2,
        OUTPUT = 3'd3,
        DONE   = 3'd4
    } avg_state_e;

    typedef logic [SUM_W-1:0] pixel_sum_t;
    typedef logic [PIX_W-1:0] pixel_t;

    // Clamp a full-width quotient to the 8-bit pixel range.
    function automatic pixel_t saturate_pixel(input logic [DIV_W-1:0] q);
        if (|q[DIV_W-1:PIX_W]) begin
            return '1;
        end
        return q[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first,
// DIV_W iterations after a start. The remainder is kept internally only.
// done is high during the final iteration cycle, and quotient carries the
// finished result in that same cycle (it is the combinational next value).
module seq_divider
    import image_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int STEP_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0]  quo_q;     // dividend bits shift out the top, quotient bits shift in the bottom
    logic [CNT_W-1:0]  rem_q;     // partial remainder, always < divisor
    logic [CNT_W-1:0]  dsr_q;
    logic [STEP_W-1:0] steps_q;

    logic [CNT_W:0]    trial;
    logic [CNT_W-1:0]  diff;
    logic              fits;
    logic [CNT_W-1:0]  rem_next;
    logic [DIV_W-1:0]  quo_next;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        trial    = {rem_q, quo_q[DIV_W-1]};
        fits     = (trial >= {1'b0, dsr_q});
        // When it fits the true difference is below the divisor, so the low bits are exact.
        diff     = trial[CNT_W-1:0] - dsr_q;
        rem_next = fits ? diff : trial[CNT_W-1:0];
        quo_next = {quo_q[DIV_W-2:0], fits};
    end

    // Iteration registers: load on start, then step DIV_W times.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q   <= '0;
            rem_q   <= '0;
            dsr_q   <= '0;
            steps_q <= '0;
            busy    <= 1'b0;
        end else if (start && !busy) begin
            quo_q   <= dividend;
            rem_q   <= '0;
            dsr_q   <= divisor;
            steps_q <= STEP_W'(DIV_W);
            busy    <= 1'b1;
        end else if (busy) begin
            quo_q   <= quo_next;
            rem_q   <= rem_next;
            steps_q <= steps_q - 1'b1;
            if (steps_q == STEP_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done     = busy && (steps_q == STEP_W'(1));
    assign quotient = quo_next;

endmodule

// File: rtl/average_image_divider.sv
// Average-image divider: divides each of the NPIX accumulated pixel sums by
// image_count using a shared sequential divider and streams 8-bit, saturated
// average pixels out in index order.
// Build option: define AVG_ROUND_EN for round-half-up averaging; otherwise the
// division truncates (floor).
//
// Output handshake: pix_valid/pix_data/pix_index are driven from registers
// only. Once pix_valid is high, pix_data and pix_index hold until a cycle
// with pix_valid && out_ready; that cycle transfers the pixel and pix_valid
// drops on the following cycle. out_ready never reaches pix_valid
// combinationally.
module average_image_divider
    import image_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NPIX-1:0][SUM_W-1:0]  sum_image,
    input  logic [CNT_W-1:0]            image_count,
    output logic                        busy,
    output logic                        pix_valid,
    input  logic                        out_ready,
    output logic [PIX_W-1:0]            pix_data,
    output logic [IDX_W-1:0]            pix_index,
    output logic                        done,
    output logic                        err_div_zero,
    output logic [2:0]                  dbg_state
);

    avg_state_e       state_q;
    avg_state_e       state_d;
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] idx_q;
    pixel_t           pix_q;
    logic             err_q;

    logic             accept_start;
    logic             handshake;
    logic             last_pixel;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] quotient;

    assign accept_start = (state_q == IDLE) && start && (image_count != '0);
    assign handshake    = (state_q == OUTPUT) && out_ready;
    assign last_pixel   = (idx_q == IDX_W'(NPIX - 1));
    assign div_start    = (state_q == LOAD) && !div_busy;

    // Dividend for the current pixel, widened by one bit to hold the rounding carry.
    always_comb begin
        dividend = {1'b0, sum_image[idx_q]};
`ifdef AVG_ROUND_EN
        dividend = dividend + DIV_W'(count_q >> 1);
`endif
    end

    seq_divider u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (count_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    // Next-state logic for the per-pixel load/divide/output loop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_start) state_d = LOAD;
            LOAD:    state_d = DIVIDE;
            DIVIDE:  if (div_done) state_d = OUTPUT;
            OUTPUT:  if (out_ready) state_d = last_pixel ? DONE : LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, captured divisor, pixel index, output pixel and zero-divisor flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            pix_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == IDLE) && start && (image_count == '0);
            if (accept_start) begin
                count_q <= image_count;
                idx_q   <= '0;
            end else if (handshake && !last_pixel) begin
                idx_q <= idx_q + 1'b1;
            end
            if ((state_q == DIVIDE) && div_done) begin
                pix_q <= saturate_pixel(quotient);
            end
        end
    end

    assign busy         = (state_q != IDLE);
    assign pix_valid    = (state_q == OUTPUT);
    assign done         = (state_q == DONE);
    assign pix_data     = pix_q;
    assign pix_index    = idx_q;
    assign err_div_zero = err_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_average_image_divider.sv
// Bench for average_image_divider: table-driven single-pixel vectors plus
// hand-written sequences for full frames, stalls, zero divisor and reset.
`timescale 1ns/1ps
module tb_average_image_divider;
    import image_pkg::*;

`ifdef AVG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic                       clk = 1'b0;
    logic                       reset;
    logic                       start;
    logic [NPIX-1:0][SUM_W-1:0] sum_image;
    logic [CNT_W-1:0]           image_count;
    logic                       busy;
    logic                       pix_valid;
    logic                       out_ready;
    logic [PIX_W-1:0]           pix_data;
    logic [IDX_W-1:0]           pix_index;
    logic                       done;
    logic                       err_div_zero;
    logic [2:0]                 dbg_state;

    always #5 clk = ~clk;

    average_image_divider dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .sum_image    (sum_image),
        .image_count  (image_count),
        .busy         (busy),
        .pix_valid    (pix_valid),
        .out_ready    (out_ready),
        .pix_data     (pix_data),
        .pix_index    (pix_index),
        .done         (done),
        .err_div_zero (err_div_zero),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [PIX_W-1:0] exp_q[$];

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_const(input logic [SUM_W-1:0] s);
        for (int i = 0; i < NPIX; i++) sum_image[i] = s;
    endtask

    // Waits (bounded) for pix_valid; returns negedges counted since the start negedge.
    task automatic wait_valid(input string name, output int lat);
        lat = 1;
        while (!pix_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!pix_valid) check({name, "_timeout"}, 0, 1);
    endtask

    // Runs one whole frame with out_ready high; every pixel is expected to equal e.
    task automatic run_frame(input string tag, input logic [SUM_W-1:0] s,
                             input logic [CNT_W-1:0] c, input logic [PIX_W-1:0] e,
                             input bit poke);
        int cyc, got, bad_d, bad_i, done_cnt, err_cnt, exp_idx;
        bit last_hs, finished, done_on_time;
        logic busy_after, done_after;
        cyc = 0; got = 0; bad_d = 0; bad_i = 0; done_cnt = 0; err_cnt = 0; exp_idx = 0;
        last_hs = 0; finished = 0; done_on_time = 0;
        exp_q.delete();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(e);
        fill_const(s);
        image_count = c;
        out_ready   = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!finished && cyc < 30000) begin
            if (done) done_cnt++;
            if (err_div_zero) err_cnt++;
            if (last_hs) begin
                done_on_time = done;
                finished     = 1;
            end else if (pix_valid && out_ready) begin
                got++;
                if (exp_q.size() == 0) bad_d++;
                else if (pix_data != exp_q.pop_front()) bad_d++;
                if (pix_index != IDX_W'(exp_idx)) bad_i++;
                exp_idx++;
                if (pix_index == IDX_W'(NPIX - 1)) last_hs = 1;
            end
            if (poke && (cyc == 40 || cyc == 9000)) begin
                start       = 1'b1;
                image_count = '0;
            end else begin
                start       = 1'b0;
                image_count = c;
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        image_count = c;
        @(negedge clk);
        busy_after = busy;
        done_after = done;
        check({tag, "_finished"}, finished, 1);
        check({tag, "_pixels"}, got, NPIX);
        check({tag, "_bad_data"}, bad_d, 0);
        check({tag, "_bad_index"}, bad_i, 0);
        check({tag, "_done_after_last"}, done_on_time, 1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_single"}, done_after, 0);
        check({tag, "_busy_after_done"}, busy_after, 0);
        check({tag, "_no_err"}, err_cnt, 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic [PIX_W-1:0] exp_trunc;
        logic [PIX_W-1:0] exp_round;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, stall_bad, pv_seen, busy_seen;
        logic [PIX_W-1:0] want;

        vecs[0]  = '{24'd10,       16'd4,     8'd2,   8'd3};
        vecs[1]  = '{24'd3000,     16'd2,     8'd255, 8'd255};
        vecs[2]  = '{24'd200,      16'd1,     8'd200, 8'd200};
        vecs[3]  = '{24'd0,        16'd5,     8'd0,   8'd0};
        vecs[4]  = '{24'd1000,     16'd7,     8'd142, 8'd143};
        vecs[5]  = '{24'd765,      16'd3,     8'd255, 8'd255};
        vecs[6]  = '{24'd768,      16'd3,     8'd255, 8'd255};
        vecs[7]  = '{24'd1021,     16'd4,     8'd255, 8'd255};
        vecs[8]  = '{24'd5,        16'd2,     8'd2,   8'd3};
        vecs[9]  = '{24'd7,        16'd2,     8'd3,   8'd4};
        vecs[10] = '{24'd32768,    16'd65535, 8'd0,   8'd1};
        vecs[11] = '{24'd100,      16'd65535, 8'd0,   8'd0};
        vecs[12] = '{24'hFFFFFF,   16'd65535, 8'd255, 8'd255};
        vecs[13] = '{24'hFFFFFF,   16'd1,     8'd255, 8'd255};
        vecs[14] = '{24'd2294,     16'd9,     8'd254, 8'd255};
        vecs[15] = '{24'd600,      16'd3,     8'd200, 8'd200};

        // Reset state
        reset = 1'b0; start = 1'b0; out_ready = 1'b0; image_count = '0;
        fill_const('0);
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err_div_zero, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_index", pix_index, 0);
        check("rst_state", dbg_state, IDLE);

        // Single-pixel vectors: first pixel value, index and latency from start.
        for (int v = 0; v < NV; v++) begin
            apply_reset();
            fill_const(vecs[v].sum);
            image_count = vecs[v].count;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_valid($sformatf("vec%0d", v), lat);
            want = ROUND ? vecs[v].exp_round : vecs[v].exp_trunc;
            check($sformatf("vec%0d_data", v), pix_data, want);
            check($sformatf("vec%0d_index", v), pix_index, 0);
            check($sformatf("vec%0d_latency", v), lat, SUM_W + 3);
        end

        // Zero divisor: single error pulse, never busy, never valid.
        apply_reset();
        image_count = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("dz_err_pulse", err_div_zero, 1);
        check("dz_busy", busy, 0);
        @(negedge clk);
        check("dz_err_single", err_div_zero, 0);
        pv_seen = 0; busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (pix_valid) pv_seen++;
            if (busy) busy_seen++;
        end
        check("dz_no_valid", pv_seen, 0);
        check("dz_no_busy", busy_seen, 0);

        // Back-pressure: output held stable while out_ready is low, transferred once.
        apply_reset();
        for (int i = 0; i < NPIX; i++) sum_image[i] = SUM_W'((i + 5) * 3);
        image_count = 16'd3;
        out_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("stall", lat);
        check("stall_first_data", pix_data, 5);
        check("stall_first_index", pix_index, 0);
        stall_bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!pix_valid || pix_data != 8'd5 || pix_index != '0) stall_bad++;
        end
        check("stall_stable", stall_bad, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_valid_drop", pix_valid, 0);
        check("stall_next_load", dbg_state, LOAD);
        wait_valid("stall2", lat);
        check("stall_second_data", pix_data, 6);
        check("stall_second_index", pix_index, 1);

        // Reset in the middle of dividing pixel 100, then a clean restart.
        apply_reset();
        for (int i = 0; i < NPIX; i++) sum_image[i] = SUM_W'(i + 7);
        image_count = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!(pix_valid && pix_index == IDX_W'(99)) && lat < 5000) begin
            @(negedge clk);
            lat++;
        end
        check("mid_reach_99", pix_index, 99);
        repeat (5) @(negedge clk);
        check("mid_in_divide", dbg_state, DIVIDE);
        check("mid_index", pix_index, 100);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_index", pix_index, 0);
        check("mid_rst_done_err", {done, err_div_zero}, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_idle_busy", busy, 0);
        check("mid_idle_valid", pix_valid, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("restart", lat);
        check("restart_index", pix_index, 0);
        check("restart_data", pix_data, 7);

        // Full frames: count=1 all 200, then count=784 all 0xFFFFFF with stray starts.
        apply_reset();
        run_frame("frame_c1", 24'd200, 16'd1, 8'd200, 1'b0);
        apply_reset();
        run_frame("frame_sat", 24'hFFFFFF, 16'd784, 8'd255, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
